// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int PC_WIDTH_DEF    = 19;
    localparam int INSTR_WIDTH_DEF = 32;
    localparam int RESET_PC_DEF    = 0;

    // One fetch queue slot: the instruction word tagged with its own PC.
    typedef struct packed {
        logic [PC_WIDTH_DEF-1:0]    pc;
        logic [INSTR_WIDTH_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and decode-side signals.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake towards decode; imem has no stall.
// Ports: master = fetch stage side, slave = memory/execute/decode side.
interface fetch_if import fetch_pkg::*; #(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch queue with push, pop and single-cycle flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller's credit scheme must never push when full.
// Ports: clk/reset, flush_i, push_i/push_dat_i, pop_i, head_dat_o, count_o.
module fetch_fifo import fetch_pkg::*; #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_dat_i,
    input  logic                   pop_i,
    output entry_t                 head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    entry_t        mem_q [DEPTH];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (reset && !flush_i && push_i) mem_q[tail_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && !flush_i) begin
            assert (!(push_i && !pop_i && count_q == FULL));
            assert (!(pop_i && count_q == '0));
        end
    end
`endif

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues imem reads, queues returned words for decode.
// Latency: first instruction valid 2 cycles after reset release or a redirect edge; 1/cycle steady.
// Backpressure: credit-limited issue; out_ready=0 stalls requests once the queue plus in-flight is full.
// Ports: clk, reset (sync, active-low), bus (fetch_if.master: imem, redirect, decode handshake).
module fetch_stage import fetch_pkg::*; #(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(1),
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
    parameter int                  DEPTH       = 2
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;

    logic [CW-1:0] count;
    entry_t        head_dat, push_dat;
    logic          out_vld, pop, push, flush, req;
    logic [CW:0]   used, avail;

    assign out_vld = reset && (count != '0);

    // credit > 0 rewritten without subtraction: count + inflight < DEPTH + pop.
    // The pop term makes imem_req combinational on out_ready.
    assign used  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign avail = (CW+1)'(DEPTH) + {{CW{1'b0}}, out_vld & bus.out_ready};
    assign req   = reset && !bus.redirect && (used < avail);

    // A redirect drops the response landing this cycle and voids any pop.
    assign flush    = !reset || bus.redirect;
    assign push     = reset && !bus.redirect && inflight_q;
    assign pop      = out_vld && bus.out_ready && !bus.redirect;
    assign push_dat = {inflight_pc_q, bus.imem_rdata};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc;
        end else if (req) begin
            pc_d          = pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    // Outputs are forced quiet while reset is low, before the first reset edge lands.
    assign bus.imem_req  = req;
    assign bus.imem_addr = reset ? pc_q : RESET_PC;
    assign bus.out_valid = out_vld;
    assign bus.out_instr = out_vld ? head_dat.instr : '0;
    assign bus.out_pc    = out_vld ? head_dat.pc    : '0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int PW = 19;
    localparam int IW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          rdy, rdy2, redir;
    logic [PW-1:0] rpc;

    fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus1 ();
    fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus2 ();

    assign bus1.out_ready   = rdy;
    assign bus1.redirect    = redir;
    assign bus1.redirect_pc = rpc;
    assign bus2.out_ready   = rdy2;
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = '0;

    function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] pc);
        return 32'h1000_0000 + {13'b0, pc};
    endfunction

    // Instruction memory models: fixed one-cycle read latency.
    always @(posedge clk) bus1.imem_rdata <= bus1.imem_req ? instr_of(bus1.imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) bus2.imem_rdata <= bus2.imem_req ? instr_of(bus2.imem_addr) : 32'hDEAD_BEEF;

    fetch_stage dut1 (.clk(clk), .reset(reset), .bus(bus1));
    fetch_stage #(.RESET_PC(19'h7FFFE)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_vec = 0, n_err = 0, pops1 = 0, pops2 = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp2_q[$];
    logic [PW-1:0] e1, e2;

    function automatic void sb_load(input logic [PW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + PW'(i));
    endfunction

    function automatic void sb2_load();
        exp2_q.delete();
        for (int i = 0; i < 16; i++) exp2_q.push_back(19'h7FFFE + PW'(i));
    endfunction

    // Scoreboard: every accepted output is popped against the expected stream.
    always @(negedge clk) begin
        if (reset === 1'b1 && redir === 1'b0 && bus1.out_valid === 1'b1 && rdy === 1'b1) begin
            n_vec++; pops1++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL sb1_unexpected got pc=%h", bus1.out_pc);
            end else begin
                e1 = exp_q.pop_front();
                if (bus1.out_pc !== e1 || bus1.out_instr !== instr_of(e1)) begin
                    n_err++;
                    $display("FAIL sb1_data got pc=%h instr=%h want pc=%h instr=%h",
                             bus1.out_pc, bus1.out_instr, e1, instr_of(e1));
                end
            end
        end
        if (reset === 1'b1 && bus2.out_valid === 1'b1 && rdy2 === 1'b1) begin
            n_vec++; pops2++;
            if (exp2_q.size() == 0) begin
                n_err++; $display("FAIL sb2_unexpected got pc=%h", bus2.out_pc);
            end else begin
                e2 = exp2_q.pop_front();
                if (bus2.out_pc !== e2 || bus2.out_instr !== instr_of(e2)) begin
                    n_err++;
                    $display("FAIL sb2_data got pc=%h instr=%h want pc=%h instr=%h",
                             bus2.out_pc, bus2.out_instr, e2, instr_of(e2));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; rdy = 1'b1; sb_load('0); sb2_load();
        repeat (3) tick();
        #1;
        n_vec++; if (bus1.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b want=0", bus1.imem_req); end
        n_vec++; if (bus1.imem_addr !== 19'h0) begin n_err++; $display("FAIL rst_addr got=%h want=0", bus1.imem_addr); end
        n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b want=0", bus1.out_valid); end
        n_vec++; if (bus1.out_instr !== 32'h0 || bus1.out_pc !== 19'h0) begin
            n_err++; $display("FAIL rst_out got instr=%h pc=%h want 0/0", bus1.out_instr, bus1.out_pc); end
        n_vec++; if (bus2.imem_addr !== 19'h7FFFE) begin n_err++; $display("FAIL rst_addr2 got=%h want=7fffe", bus2.imem_addr); end
        reset = 1'b1;
        #1;
        n_vec++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 19'h0) begin
            n_err++; $display("FAIL rel_req got req=%b addr=%h want 1/0", bus1.imem_req, bus1.imem_addr); end
        tick(); #1;
        n_vec++; if (bus1.out_valid !== 1'b0 || bus1.imem_addr !== 19'h1) begin
            n_err++; $display("FAIL rel_e1 got vld=%b addr=%h want 0/1", bus1.out_valid, bus1.imem_addr); end
        tick(); #1;
        n_vec++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 19'h0) begin
            n_err++; $display("FAIL rel_e2 got vld=%b pc=%h want 1/0", bus1.out_valid, bus1.out_pc); end
    endtask

    task automatic test_stream();
        int p0;
        p0 = pops1;
        repeat (8) begin
            tick(); #1;
            n_vec++; if (bus1.out_valid !== 1'b1 || bus1.imem_req !== 1'b1) begin
                n_err++; $display("FAIL stream_rate got vld=%b req=%b want 1/1", bus1.out_valid, bus1.imem_req); end
        end
        n_vec++; if (pops1 - p0 !== 8) begin n_err++; $display("FAIL stream_count got=%0d want=8", pops1 - p0); end
    endtask

    task automatic test_backpressure();
        int p0;
        rdy = 1'b0;
        #1;
        n_vec++; if (bus1.imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req0 got=%b want=0", bus1.imem_req); end
        repeat (6) begin
            tick(); #1;
            n_vec++; if (bus1.out_valid !== 1'b1 || bus1.imem_req !== 1'b0) begin
                n_err++; $display("FAIL bp_stall got vld=%b req=%b want 1/0", bus1.out_valid, bus1.imem_req); end
            n_vec++; if (bus1.out_pc !== exp_q[0] || bus1.out_instr !== instr_of(exp_q[0])) begin
                n_err++; $display("FAIL bp_hold got pc=%h instr=%h want pc=%h", bus1.out_pc, bus1.out_instr, exp_q[0]); end
        end
        rdy = 1'b1;
        p0 = pops1;
        repeat (6) begin
            tick(); #1;
            n_vec++; if (bus1.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_resume got vld=%b want=1", bus1.out_valid); end
        end
        n_vec++; if (pops1 - p0 !== 6) begin n_err++; $display("FAIL bp_count got=%0d want=6", pops1 - p0); end
    endtask

    task automatic test_redirect();
        redir = 1'b1; rpc = 19'h00400; sb_load(19'h00400);
        #1;
        n_vec++; if (bus1.imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req got=%b want=0", bus1.imem_req); end
        tick(); redir = 1'b0; #1;
        n_vec++; if (bus1.out_valid !== 1'b0 || bus1.imem_addr !== 19'h00400 || bus1.imem_req !== 1'b1) begin
            n_err++; $display("FAIL rd_restart got vld=%b addr=%h req=%b want 0/00400/1",
                              bus1.out_valid, bus1.imem_addr, bus1.imem_req); end
        tick(); #1;
        n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL rd_bubble got vld=%b want=0", bus1.out_valid); end
        tick(); #1;
        n_vec++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 19'h00400) begin
            n_err++; $display("FAIL rd_first got vld=%b pc=%h want 1/00400", bus1.out_valid, bus1.out_pc); end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back_redirect();
        rdy = 1'b0;
        tick(); tick();
        rdy = 1'b1; redir = 1'b1; rpc = 19'h00100; sb_load(19'h00100);
        #1;
        n_vec++; if (bus1.imem_req !== 1'b0 || bus1.out_valid !== 1'b1) begin
            n_err++; $display("FAIL r2_first got req=%b vld=%b want 0/1", bus1.imem_req, bus1.out_valid); end
        tick(); rpc = 19'h00200; sb_load(19'h00200); #1;
        n_vec++; if (bus1.out_valid !== 1'b0 || bus1.imem_req !== 1'b0) begin
            n_err++; $display("FAIL r2_second got vld=%b req=%b want 0/0", bus1.out_valid, bus1.imem_req); end
        tick(); redir = 1'b0; #1;
        n_vec++; if (bus1.imem_addr !== 19'h00200 || bus1.out_valid !== 1'b0) begin
            n_err++; $display("FAIL r2_addr got addr=%h vld=%b want 00200/0", bus1.imem_addr, bus1.out_valid); end
        tick(); tick(); #1;
        n_vec++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 19'h00200) begin
            n_err++; $display("FAIL r2_out got vld=%b pc=%h want 1/00200", bus1.out_valid, bus1.out_pc); end
        repeat (4) tick();
    endtask

    task automatic test_wrap();
        reset = 1'b0; sb_load('0); sb2_load(); rdy2 = 1'b1;
        tick(); reset = 1'b1; #1;
        n_vec++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 19'h7FFFE) begin
            n_err++; $display("FAIL wr_req got req=%b addr=%h want 1/7fffe", bus2.imem_req, bus2.imem_addr); end
        tick(); #1;
        n_vec++; if (bus2.imem_addr !== 19'h7FFFF) begin n_err++; $display("FAIL wr_addr got=%h want=7ffff", bus2.imem_addr); end
        tick(); #1;
        n_vec++; if (bus2.out_valid !== 1'b1 || bus2.out_pc !== 19'h7FFFE) begin
            n_err++; $display("FAIL wr_pc0 got vld=%b pc=%h want 1/7fffe", bus2.out_valid, bus2.out_pc); end
        tick(); #1;
        n_vec++; if (bus2.out_pc !== 19'h7FFFF) begin n_err++; $display("FAIL wr_pc1 got=%h want=7ffff", bus2.out_pc); end
        tick(); #1;
        n_vec++; if (bus2.out_pc !== 19'h00000) begin n_err++; $display("FAIL wr_pc2 got=%h want=00000", bus2.out_pc); end
        tick(); #1;
        n_vec++; if (bus2.out_pc !== 19'h00001) begin n_err++; $display("FAIL wr_pc3 got=%h want=00001", bus2.out_pc); end
        tick();
        rdy2 = 1'b0;
        n_vec++; if (pops2 < 4) begin n_err++; $display("FAIL wr_count got=%0d want>=4", pops2); end
    endtask

    task automatic test_reset_midstream();
        rdy = 1'b0;
        repeat (3) tick();
        reset = 1'b0; sb_load('0); sb2_load();
        #1;
        n_vec++; if (bus1.out_valid !== 1'b0 || bus1.imem_req !== 1'b0) begin
            n_err++; $display("FAIL mr_in got vld=%b req=%b want 0/0", bus1.out_valid, bus1.imem_req); end
        tick(); reset = 1'b1; rdy = 1'b1; #1;
        n_vec++; if (bus1.out_valid !== 1'b0 || bus1.imem_req !== 1'b1 || bus1.imem_addr !== 19'h0) begin
            n_err++; $display("FAIL mr_rel got vld=%b req=%b addr=%h want 0/1/0",
                              bus1.out_valid, bus1.imem_req, bus1.imem_addr); end
        tick(); tick(); #1;
        n_vec++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 19'h0) begin
            n_err++; $display("FAIL mr_first got vld=%b pc=%h want 1/0", bus1.out_valid, bus1.out_pc); end
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b0; rdy = 1'b0; rdy2 = 1'b0; redir = 1'b0; rpc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back_redirect();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage that owns the program counter, issues instruction-memory reads and buffers the returned instructions for the decode stage.
- Sits between the PC-register/flip-flop layer and the IF/ID pipeline register; consumes branch redirects from execute.
- Sustains one instruction per cycle through a small credit-controlled queue.
- Absorbs decode back-pressure without losing or duplicating any instruction.

Parameters:
- PC_WIDTH, 19, width of PC and instruction-memory address.
- INSTR_WIDTH, 32, instruction word width.
- PC_STEP, 1, PC increment per fetched instruction (word-addressed memory).
- RESET_PC, 0, PC value after reset.
- DEPTH, 2, fetch queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  PC_WIDTH  read address; equals current PC.
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after an accepted imem_req (fixed 1-cycle latency, no stall).
- redirect  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  PC_WIDTH  restart address, sampled when redirect=1.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts the entry this cycle.
- out_instr  out  INSTR_WIDTH  head-of-queue instruction.
- out_pc  out  PC_WIDTH  PC of out_instr.

Behaviour:
- Reset (reset=0 at a rising edge):
  - pc<=RESET_PC; count, head, tail <=0; inflight<=0.
  - Outputs while in reset: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - Reset asserted mid-operation discards queue contents and any in-flight response.
- Credit: credit = DEPTH - count - inflight + (out_valid & out_ready).
  - imem_req = reset & ~redirect & (credit>0).
  - imem_req depends combinationally on out_ready (documented path).
- Issue: when imem_req=1, next edge sets pc<=pc+PC_STEP (modulo 2^PC_WIDTH; wrap from all-ones to 0 is legal), inflight<=1, and inflight_pc<=pc.
  - When imem_req=0, inflight<=0.
- Response: when inflight=1 and no redirect this cycle, the next edge writes {inflight_pc, imem_rdata} into queue[tail], tail<=tail+1 mod DEPTH.
- Pop: out_valid=(count!=0); out_instr/out_pc = queue[head].
  - out_valid & out_ready & ~redirect → head<=head+1 mod DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- The credit rule guarantees a push never occurs into a full queue. Overflow is a design error and must be asserted against in simulation.
- Redirect (priority over everything except reset):
  - Next edge sets pc<=redirect_pc, count/head/tail<=0, inflight<=0.
  - The in-flight response arriving during the redirect cycle is dropped, and any pop that cycle is void.
  - imem_req=0 in the redirect cycle; first request to redirect_pc the following cycle.
  - Redirect on consecutive cycles: the last one wins.
- Latency:
  - Reset release at edge E0: imem_req=1, addr=RESET_PC in cycle after E0; data captured at E2; out_valid=1 after E2.
  - Same 2-cycle redirect-to-first-instruction bubble after the redirect edge.
- Throughput: with out_ready held 1, one instruction per cycle in steady state.
- out_ready=0 with a full queue: imem_req=0, outputs stable until accepted.
- Output stability: while out_valid=1 and out_ready=0 and no redirect, out_instr/out_pc must not change.

Decomposition:
- Package fetch_pkg: PC_WIDTH and INSTR_WIDTH defaults, RESET_PC default, typedef fetch_entry_t {pc, instr} packed struct.
- Sub-module fetch_fifo: circular buffer of fetch_entry_t with push/pop/flush, count, head, tail. fetch_stage holds the PC, credit and in-flight tracking.

Test Plan:
- Reset held 3 cycles then released, out_ready=1, imem returns instr=0x1000_0000+addr → out_valid rises 2 cycles after release; out_pc sequence 0,1,2,3… one per cycle with matching instr.
- out_ready=0 from cycle 5 for 6 cycles → queue fills to 2, imem_req=0 and out_pc frozen; on release, PCs resume with no gap or duplicate.
- redirect=1, redirect_pc=0x00400 while queue holds 2 entries and a response is in flight → next cycle out_valid=0; imem_addr=0x00400 one cycle later; first out_pc=0x00400; stale PCs never appear.
- Start at RESET_PC=0x7FFFE with PC_STEP=1 → out_pc 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- Redirect on two consecutive cycles (targets 0x100 then 0x200), plus redirect coinciding with out_ready pop → only the 0x200 stream delivered; the popped entry is not counted as consumed.
- reset driven low mid-stream with queue full → next cycle out_valid=0, imem_req=0; after release, fetch restarts at RESET_PC.
